// File: rtl/cram_pkg.sv
// Shared definitions for the CRAM palette loader: state encoding, CRAM geometry
// and the transfer-length decode helper.
package cram_pkg;

    localparam int CRAM_AW    = 8;
    localparam int CRAM_DW    = 16;
    localparam int CRAM_DEPTH = 256;
    localparam int CNT_W      = $clog2(CRAM_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } cram_state_e;

    // A length field of zero encodes a full-table transfer.
    function automatic logic [CNT_W-1:0] len_to_count(input logic [CRAM_AW-1:0] len);
        logic [CNT_W-1:0] cnt;
        if (len == {CRAM_AW{1'b0}}) begin
            cnt = CNT_W'(CRAM_DEPTH);
        end else begin
            cnt = CNT_W'(len);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cram_loader.sv
// Copies a block of 16-bit words from source memory into palette CRAM, one
// read/write pair per entry. Define CRAM_LOADER_VBLANK_EN to gate writes on tv_blank.
module cram_loader #(
    parameter int SRC_AW = 21
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [SRC_AW-1:0]            src_addr,
    input  logic [cram_pkg::CRAM_AW-1:0] dst_addr,
    input  logic [cram_pkg::CRAM_AW-1:0] len,
    input  logic                         tv_blank,
    output logic                         mem_req,
    output logic [SRC_AW-1:0]            mem_addr,
    input  logic                         mem_rdy,
    input  logic [cram_pkg::CRAM_DW-1:0] mem_data,
    output logic [cram_pkg::CRAM_AW-1:0] cram_addr,
    output logic [cram_pkg::CRAM_DW-1:0] cram_data,
    output logic                         cram_we,
    output logic                         busy,
    output logic                         done
);
    import cram_pkg::*;

    cram_state_e          state_q;
    logic [SRC_AW-1:0]    src_q;
    logic [SRC_AW-1:0]    src_d;
    logic [CRAM_AW-1:0]   dst_q;
    logic [CRAM_AW-1:0]   dst_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CRAM_DW-1:0]   data_q;
    logic                 mem_req_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 blank_ok_s;
    logic                 write_fire_s;
    logic                 last_s;

`ifdef CRAM_LOADER_VBLANK_EN
    // Write window opens only while the display is blanked.
    always_comb begin
        blank_ok_s = tv_blank;
    end
`else
    logic unused_tv_blank_s;

    // Blanking is irrelevant in this build; the flag is deliberately sunk.
    always_comb begin
        unused_tv_blank_s = tv_blank;
        blank_ok_s        = 1'b1;
    end
`endif

    // Post-write address/count advance and the write strobe qualification.
    always_comb begin
        src_d        = src_q + SRC_AW'(1);
        dst_d        = dst_q + CRAM_AW'(1);
        cnt_d        = cnt_q - CNT_W'(1);
        last_s       = (cnt_q == CNT_W'(1));
        write_fire_s = (state_q == ST_WRITE) && !abort && blank_ok_s;
    end

    // Transfer state machine with its registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= {SRC_AW{1'b0}};
            dst_q     <= {CRAM_AW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            data_q    <= {CRAM_DW{1'b0}};
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort outranks a simultaneous start
                    if (start && !abort) begin
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        cnt_q     <= len_to_count(len);
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_REQ;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end else if (mem_rdy) begin
                        data_q    <= mem_data;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_WRITE;
                    end else begin
                        state_q   <= ST_REQ;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end else if (write_fire_s) begin
                        src_q <= src_d;
                        dst_q <= dst_d;
                        cnt_q <= cnt_d;
                        if (last_s) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            mem_req_q <= 1'b1;
                            state_q   <= ST_REQ;
                        end
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // abort suppresses the strobes of the cycle in which it arrives.
    always_comb begin
        mem_req   = mem_req_q;
        mem_addr  = src_q;
        cram_addr = dst_q;
        cram_data = data_q;
        cram_we   = write_fire_s;
        busy      = busy_q;
        done      = done_q && !abort;
    end

endmodule

// File: tb/tb_cram_loader.sv
// Self-checking bench for cram_loader: randomized transfers scored against a
// queue of expected CRAM writes derived from the transfer parameters.
module tb_cram_loader;

    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [7:0]    dst_addr = 8'd0;
    logic [7:0]    len = 8'd0;
    logic          tv_blank = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy = 1'b0;
    logic [15:0]   mem_data = 16'd0;
    logic [7:0]    cram_addr;
    logic [15:0]   cram_data;
    logic          cram_we;
    logic          busy;
    logic          done;

    cram_loader #(.SRC_AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .tv_blank(tv_blank),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data),
        .cram_addr(cram_addr), .cram_data(cram_data), .cram_we(cram_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_vec = 0;
    int  n_err = 0;
    int  wr_seen = 0;
    int  done_seen = 0;
    int  delay_cfg = 0;
    bit  rand_delay = 1'b0;
    int  wait_left = 0;

    // Source memory contents: a fixed scramble of the word address.
    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[20:16], 11'h2B5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event-missing expected event at %0t", name, $time);
    endtask

    // Reference model: entry i lands at dst+i (mod 256) holding word src+i.
    task automatic push_xfer(input logic [AW-1:0] s, input logic [7:0] d,
                             input logic [7:0] l, input int keep);
        int  n;
        wr_t e;
        n = (l == 8'd0) ? 256 : int'(l);
        if (keep >= 0 && keep < n) n = keep;
        for (int i = 0; i < n; i++) begin
            e.a = d + 8'(i);
            e.d = mem_word(s + AW'(i));
            exp_q.push_back(e);
        end
    endtask

    // Memory responder: answers mem_req after a configurable number of cycles.
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            mem_rdy   = 1'b0;
            mem_data  = 16'($urandom);
            wait_left = rand_delay ? int'($urandom_range(0, 3)) : delay_cfg;
        end else if (wait_left == 0) begin
            mem_rdy  = 1'b1;
            mem_data = mem_word(mem_addr);
        end else begin
            mem_rdy  = 1'b0;
            mem_data = 16'($urandom);
            wait_left--;
        end
    end

    logic          prev_req = 1'b0;
    logic          prev_rdy = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Monitor: scores every CRAM write and watches request stability.
    always @(negedge clk) begin
        if (cram_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(cram_addr), 32'(mon_e.a));
                check("wr_data", 32'(cram_data), 32'(mon_e.d));
                check("we_without_req", 32'(mem_req), 32'd0);
            end
        end
        if (done) done_seen++;
        if (prev_req && mem_req && !prev_rdy) begin
            check("req_addr_stable", 32'(mem_addr), 32'(prev_addr));
        end
        prev_req  = mem_req;
        prev_rdy  = mem_rdy;
        prev_addr = mem_addr;
    end

    task automatic do_start(input logic [AW-1:0] s, input logic [7:0] d, input logic [7:0] l);
        @(posedge clk);
        #1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = AW'($urandom);
        dst_addr = 8'($urandom);
        len      = 8'($urandom);
    endtask

    task automatic run_xfer(input logic [AW-1:0] s, input logic [7:0] d, input logic [7:0] l,
                            input bit poke, output int cyc);
        int d0;
        bit fin;
        d0  = done_seen;
        fin = 1'b0;
        push_xfer(s, d, l, -1);
        do_start(s, d, l);
        cyc = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("req_after_start", 32'({mem_req, busy}), 32'd3);
            if (poke && cyc == 3) begin
                start    = 1'b1;
                src_addr = AW'($urandom);
                dst_addr = 8'($urandom);
                len      = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                fin = 1'b1;
            end else if (cyc > 3000) begin
                fail_now("xfer_timeout");
                fin = 1'b1;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_once", 32'(done_seen - d0), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int            cyc;
        int            d0;
        int            w0;
        int            first;
        logic [AW-1:0] s;
        logic [7:0]    d;

        #2;
        check("reset_ctrl", 32'({busy, mem_req, cram_we, done}), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_cram", 32'({cram_addr, cram_data}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic 4-entry block, zero memory wait.
        run_xfer(21'h000100, 8'h10, 8'd4, 1'b0, cyc);
        check("len4_cycles", 32'(cyc), 32'd9);

        // Full table with destination and source wrap.
        run_xfer(21'h1FFF80, 8'hFE, 8'd0, 1'b0, cyc);
        check("len256_cycles", 32'(cyc), 32'd513);

        // Slow memory: five wait cycles per word.
        delay_cfg = 5;
        run_xfer(AW'($urandom), 8'($urandom), 8'd3, 1'b0, cyc);
        check("slow_cycles", 32'(cyc), 32'd22);

        // Random transfers with random waits and stray start pulses.
        rand_delay = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_xfer(AW'($urandom), 8'($urandom), 8'($urandom_range(1, 20)), 1'b1, cyc);
        end
        rand_delay = 1'b0;
        delay_cfg  = 0;

        // Abort during the third word's request, racing mem_rdy.
        s  = AW'($urandom);
        d  = 8'($urandom);
        d0 = done_seen;
        w0 = wr_seen;
        push_xfer(s, d, 8'd8, 2);
        do_start(s, d, 8'd8);
        cyc = 0;
        while (!(wr_seen - w0 == 2 && mem_req) && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) fail_now("abort_wait_timeout");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle", 32'({busy, mem_req, cram_we, done}), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_writes", 32'(wr_seen - w0), 32'd2);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("abort_sb", 32'(exp_q.size()), 32'd0);
        run_xfer(AW'($urandom), 8'($urandom), 8'd5, 1'b0, cyc);
        check("post_abort_cycles", 32'(cyc), 32'd11);

        // start together with abort in IDLE must not launch anything.
        w0 = wr_seen;
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'({busy, mem_req}), 32'd0);
        repeat (5) @(negedge clk);
        check("start_abort_nowrite", 32'(wr_seen - w0), 32'd0);

        // Asynchronous reset in the middle of a WRITE cycle.
        push_xfer(AW'(21'h0ABCD), 8'h40, 8'd6, -1);
        do_start(AW'(21'h0ABCD), 8'h40, 8'd6);
        cyc = 0;
        while (!cram_we && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 50) fail_now("write_wait_timeout");
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", 32'({cram_we, busy, mem_req, done}), 32'd0);
        check("rst_async_addr", 32'({cram_addr, cram_data}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_xfer(AW'($urandom), 8'($urandom), 8'd3, 1'b0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd7);

        // Blanking gate: tv_blank low for ten cycles, then high.
        tv_blank = 1'b0;
        d0 = done_seen;
        s  = AW'($urandom);
        push_xfer(s, 8'h77, 8'd1, -1);
        do_start(s, 8'h77, 8'd1);
        cyc   = 1;
        first = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (cram_we && first == 0) first = cyc;
            if (done) break;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 11) tv_blank = 1'b1;
        end
        tv_blank = 1'b1;
`ifdef CRAM_LOADER_VBLANK_EN
        check("blank_first_write", 32'(first), 32'd11);
`else
        check("blank_first_write", 32'(first), 32'd2);
`endif
        @(negedge clk);
        check("blank_done", 32'(done_seen - d0), 32'd1);
        check("blank_sb", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cram_loader.md
CRAM_LOADER -- requirements
Module: cram_loader

Interface
REQ-001 Parameter SRC_AW, default 21, SHALL set the width of the source word address.
REQ-002 clk  in  1  system clock; every register SHALL be clocked on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a palette transfer.
REQ-005 abort  in  1  synchronous request to cancel a transfer in progress.
REQ-006 src_addr  in  SRC_AW  first source word address.
REQ-007 dst_addr  in  8  first CRAM entry to write.
REQ-008 len  in  8  number of entries to move; 0 SHALL mean 256.
REQ-009 tv_blank  in  1  video blanking flag; used only when CRAM_LOADER_VBLANK_EN is defined.
REQ-010 mem_req  out  1  memory read request.
REQ-011 mem_addr  out  SRC_AW  memory read word address.
REQ-012 mem_rdy  in  1  read-data-valid strobe.
REQ-013 mem_data  in  16  read data.
REQ-014 cram_addr  out  8, cram_data  out  16, cram_we  out  1  CRAM write port.
REQ-015 busy  out  1  high from the cycle after start is accepted until the cycle after done.
REQ-016 done  out  1  single-cycle completion pulse.

Function
REQ-017 The state machine SHALL have the states IDLE, REQ, WRITE and DONE.
REQ-018 In IDLE, start SHALL latch src_addr, dst_addr and len; the next state SHALL be REQ.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 REQ state: mem_req=1 and mem_addr=current source address, held steady until mem_rdy.
REQ-021 In REQ, when mem_rdy=1, mem_data SHALL be captured, mem_req SHALL drop in the next cycle, and the next state SHALL be WRITE.
REQ-022 WRITE state: cram_we SHALL be 1 for exactly one cycle, with cram_addr = current destination and cram_data = captured word.
REQ-023 After each write: destination +1 (255 wraps to 0), source +1 (modulo 2^SRC_AW), remaining count -1.
REQ-024 From WRITE, the next state SHALL be DONE if the remaining count was 1; otherwise it SHALL be REQ.
REQ-025 DONE state: done=1 for one cycle, then the machine SHALL return to IDLE.
REQ-026 With zero memory wait, throughput SHALL be 1 entry per 2 cycles; mem_req SHALL rise the cycle after start is accepted.
REQ-027 abort in any non-IDLE state SHALL force IDLE next cycle: no cram_we, no done, mem_req dropped.
REQ-028 abort SHALL take priority over mem_rdy and over the WRITE action in the same cycle.
REQ-029 start and abort asserted together in IDLE: abort SHALL win and no transfer SHALL start.
REQ-030 cram_we SHALL never be asserted outside WRITE.

Reset
REQ-031 Asserting rst SHALL immediately force state IDLE and set mem_req, cram_we, busy and done to 0.
REQ-032 On rst, mem_addr, cram_addr, cram_data and the internal counters SHALL be cleared to 0.
REQ-033 Reset during a transfer SHALL leave no partial write pending after release.

Configuration
REQ-034 Macro CRAM_LOADER_VBLANK_EN defined: WRITE SHALL hold, with cram_we=0, while tv_blank=0, and SHALL write in the first cycle tv_blank=1.
REQ-035 Macro CRAM_LOADER_VBLANK_EN undefined: tv_blank SHALL be ignored and WRITE SHALL always complete in one cycle.

Structure
REQ-036 A shared package cram_pkg SHALL hold the state enum, CRAM_AW=8, CRAM_DW=16 and CRAM_DEPTH=256.
REQ-037 The block SHALL be a single module with no sub-module.

Verification
REQ-038 len=4, dst=0x10, src=0x100, mem_rdy same cycle as req -> writes to 0x10..0x13 of words @0x100..0x103, 8 cycles, then done pulse, busy low.
REQ-039 len=0, dst=0xFE -> 256 writes; addresses 0xFE, 0xFF, 0x00..0xFD; done exactly once.
REQ-040 mem_rdy delayed 5 cycles per word -> mem_req/mem_addr stable throughout, no extra cram_we.
REQ-041 abort during third word's REQ (len=8) -> exactly 2 writes, no done, IDLE next cycle; new start then works.
REQ-042 rst asserted mid-WRITE -> cram_we and busy 0 without waiting for a clock edge; start after release begins cleanly.
REQ-043 With VBLANK_EN, tv_blank=0 for 10 cycles then 1 -> first cram_we in the first blank cycle; without the macro -> write immediately.
